mask_builder_32: RTL
====================

MASK_BUILDER_32 -- requirements
Module: mask_builder_32

Interface
REQ-001 SHALL have parameter MASK_W, default 32: width of the output mask, fixed at 32 in this revision.
REQ-002 SHALL have parameter IDX_W, default 5: width of the input index, equal to log2(MASK_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_idx, input, IDX_W bits: bit index to set in the mask.
REQ-006 SHALL have port in_last, input, 1 bit: marks the final index of a frame.
REQ-007 SHALL have port in_valid, input, 1 bit: in_idx and in_last are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an index this cycle.
REQ-009 SHALL have port out_mask, output, MASK_W bits: accumulated one-hot OR for the frame.
REQ-010 SHALL have port out_count, output, 6 bits: number of indices accepted in the frame, duplicates included.
REQ-011 SHALL have port out_dup, output, 1 bit: at least one index in the frame was already set when it arrived.
REQ-012 SHALL have port out_valid, output, 1 bit: frame result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the frame result.

Function
REQ-014 SHALL implement a two-state FSM: COLLECT and OUTPUT; reset state COLLECT.
REQ-015 SHALL drive in_ready = 1 in COLLECT and 0 in OUTPUT; out_valid = 1 in OUTPUT only.
REQ-016 SHALL define an input accept as in_valid & in_ready at a rising clk edge.
REQ-017 SHALL, on each accept, OR the 5-to-32 one-hot decode of in_idx into accumulator acc (bit k set iff in_idx == k).
REQ-018 SHALL, on each accept where acc[in_idx] is already 1, set the dup flag.
REQ-019 SHALL, on each accept, increment the count, saturating at 63.
REQ-020 SHALL, on an accept with in_last = 1, register out_mask = acc | onehot(in_idx), with out_count and out_dup including that index; clear acc, count and dup; and enter OUTPUT.
REQ-021 SHALL assert out_valid exactly one cycle after the last-index accept.
REQ-022 SHALL hold out_mask, out_count and out_dup stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL, in OUTPUT with out_ready = 1, return to COLLECT on the next edge; no index is accepted in that same cycle.
REQ-024 SHALL make a single-index frame (in_last on the first accept) yield a one-hot mask with out_count = 1 and out_dup = 0.
REQ-025 SHALL produce no frame and no out_valid while in_valid = 0; acc is held unchanged.
REQ-026 SHALL ignore in_idx and in_last whenever in_ready = 0.
REQ-027 SHALL, when index 31 and index 0 appear in the same frame, set both mask bits 31 and 0, with no wrap or truncation.

Reset
REQ-028 SHALL, with rst = 1 at an edge, force state COLLECT, acc = 0, count = 0, dup = 0, out_mask = 0, out_count = 0, out_dup = 0, out_valid = 0.
REQ-029 SHALL, on reset mid-frame or in OUTPUT, discard the partial or pending frame; no out_valid follows.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place MASK_W, IDX_W, the count width (6) and the FSM state encoding in a shared package, mask_pkg.
REQ-032 SHALL instantiate one combinational sub-module, decoder_5to32 (in: 5-bit index, out: 32-bit one-hot), as the inverse of the existing 32-bit priority encoder.
REQ-033 SHALL register all outputs except in_ready, which is decoded from the state register.

Verification
REQ-034 SHALL cover: indices 3, 7, 31 (last on 31), out_ready = 1 -> out_valid 1 cycle after the 31 accept, out_mask = 0x80000088, out_count = 3, out_dup = 0.
REQ-035 SHALL cover: indices 5, 5 (last) -> out_mask = 0x00000020, out_count = 2, out_dup = 1.
REQ-036 SHALL cover: single index 0 with last, out_ready = 0 for 4 cycles -> out_mask = 0x00000001 held stable, in_ready = 0 throughout, COLLECT on the edge after out_ready rises.
REQ-037 SHALL cover: 40 accepts of index 9, last on the 40th -> out_count = 40, out_dup = 1, mask 0x00000200; 70 accepts -> out_count = 63.
REQ-038 SHALL cover: rst pulsed after indices 1 and 2 are accepted (no last), then index 4 with last -> out_mask = 0x00000010, out_count = 1.
REQ-039 SHALL cover: all 32 indices 0..31, last on 31 -> out_mask = 0xFFFFFFFF, out_count = 32; after decoding each out_mask, the priority encoder returns the highest index sent.

Source files
------------

// File: rtl/mask_pkg.sv
// mask_pkg: shared widths and FSM state encoding for mask_builder_32
package mask_pkg;
  localparam int MASK_W = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;
  typedef enum logic {COLLECT = 1'b0, OUTPUT = 1'b1} state_t;
endpackage

// File: rtl/decoder_5to32.sv
// decoder_5to32: 5-bit index to 32-bit one-hot (idx in, onehot out), inverse of the 32-bit priority encoder
module decoder_5to32 (
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);
  assign onehot = 32'd1 << idx;
endmodule

// File: rtl/mask_builder_32.sv
// mask_builder_32: ORs one-hot indices into a per-frame mask (in_idx/in_last/in_valid/in_ready in; out_mask/out_count/out_dup/out_valid/out_ready out)
module mask_builder_32
  import mask_pkg::*;
#(
  parameter int MASK_W = mask_pkg::MASK_W,
  parameter int IDX_W = mask_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MASK_W-1:0] out_mask,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_dup,
  output logic              out_valid,
  input  logic              out_ready
);
  state_t state, state_nxt;
  logic [MASK_W-1:0] acc, onehot;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic dup, hit, accept;
  decoder_5to32 u_dec (.idx(in_idx), .onehot(onehot));
  assign in_ready = state == COLLECT;
  assign accept = in_valid & in_ready;
  assign hit = |(acc & onehot);
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == COLLECT) ? ((accept & in_last) ? OUTPUT : COLLECT) : (out_ready ? COLLECT : OUTPUT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      acc <= '0;
      cnt <= '0;
      dup <= 1'b0;
      out_mask <= '0;
      out_count <= '0;
      out_dup <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      out_valid <= state_nxt == OUTPUT;
      if (accept) begin
        acc <= in_last ? '0 : acc | onehot;
        cnt <= in_last ? '0 : cnt_inc;
        dup <= in_last ? 1'b0 : dup | hit;
        if (in_last) begin
          out_mask <= acc | onehot;
          out_count <= cnt_inc;
          out_dup <= dup | hit;
        end
      end
    end
  end
endmodule
